// File: rtl/rv_ctrl_pkg.sv
// Shared decode constants: opcodes, control-field codes and the control bundle layout.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    localparam logic [2:0] IT_R     = 3'b000;
    localparam logic [2:0] IT_I     = 3'b001;
    localparam logic [2:0] IT_S     = 3'b010;
    localparam logic [2:0] IT_B     = 3'b011;
    localparam logic [2:0] IT_U     = 3'b100;
    localparam logic [2:0] IT_J     = 3'b101;
    localparam logic [2:0] IT_AUIPC = 3'b110;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_R   = 3'b010;
    localparam logic [2:0] ALU_IMM = 3'b011;
    localparam logic [2:0] ALU_BR  = 3'b101;

    localparam logic [2:0] MEM_NONE = 3'b000;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic [2:0] aluop;
        logic [2:0] insttype;
        logic [2:0] memread;
        logic [2:0] memwrite;
        logic       regwrite;
        logic       alusrc;
        logic       memtoreg;
        logic       branch;
        logic       jump;
        logic       word;
        logic       illegal;
    } ctrl_t;

    // Load/store size codes are the func3 value offset by one (LB/SB = 001).
    function automatic logic [2:0] mem_code(input logic [2:0] func3);
        return func3 + 3'd1;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: picks the instruction's immediate field and sign-extends it to XLEN.
module imm_gen
    import rv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32_s;

    // Assemble the 32-bit immediate for the selected format.
    always_comb begin
        imm32_s = 32'd0;
        case (fmt)
            IMM_I:   imm32_s = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32_s = {instr[31:12], 12'd0};
            IMM_J:   imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32_s = 32'd0;
        endcase
    end

    assign imm = XLEN'($signed(imm32_s));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32/RV64 decode stage with valid/ready handshake, load-use interlock and flush.
module decode_stage
    import rv_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [XLEN-1:0]        in_pc,
    input  logic                   flush,
    input  logic                   ex_is_load,
    input  logic [4:0]             ex_rd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic [4:0]             out_rd,
    output logic [XLEN-1:0]        out_imm,
    output logic [2:0]             out_aluop,
    output logic [2:0]             out_insttype,
    output logic [2:0]             out_memread,
    output logic [2:0]             out_memwrite,
    output logic                   out_regwrite,
    output logic                   out_alusrc,
    output logic                   out_memtoreg,
    output logic                   out_branch,
    output logic                   out_jump,
    output logic                   out_word,
    output logic                   out_illegal,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]      opcode_s;
    logic [2:0]      func3_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    ctrl_t           ctrl_s;
    ctrl_t           ctrl_r;
    imm_fmt_e        fmt_s;
    logic            uses_rs1_s;
    logic            uses_rs2_s;
    logic            hazard_s;
    logic            accept_s;
    logic [XLEN-1:0] imm_s;

    assign opcode_s = in_instr[6:0];
    assign func3_s  = in_instr[14:12];
    assign rs1_s    = in_instr[19:15];
    assign rs2_s    = in_instr[24:20];

    // Opcode decode; illegal encodings leave every control field cleared except illegal.
    always_comb begin
        ctrl_s     = '0;
        fmt_s      = IMM_NONE;
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b0;
        case (opcode_s)
            OPC_OP, OPC_OP_32: begin
                uses_rs2_s = 1'b1;
                if ((opcode_s == OPC_OP_32) && !RV64) begin
                    ctrl_s.illegal = 1'b1;
                end else begin
                    ctrl_s.insttype = IT_R;
                    ctrl_s.aluop    = ALU_R;
                    ctrl_s.regwrite = 1'b1;
                    ctrl_s.word     = (opcode_s == OPC_OP_32);
                end
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                if ((opcode_s == OPC_OP_IMM_32) && !RV64) begin
                    ctrl_s.illegal = 1'b1;
                end else begin
                    ctrl_s.insttype = IT_I;
                    ctrl_s.aluop    = ALU_IMM;
                    ctrl_s.regwrite = 1'b1;
                    ctrl_s.alusrc   = 1'b1;
                    ctrl_s.word     = (opcode_s == OPC_OP_IMM_32);
                    fmt_s           = IMM_I;
                end
            end
            OPC_LOAD: begin
                if ((func3_s == 3'b111) || (!RV64 && ((func3_s == 3'b011) || (func3_s == 3'b110)))) begin
                    ctrl_s.illegal = 1'b1;
                end else begin
                    ctrl_s.insttype = IT_I;
                    ctrl_s.memread  = mem_code(func3_s);
                    ctrl_s.regwrite = 1'b1;
                    ctrl_s.alusrc   = 1'b1;
                    ctrl_s.memtoreg = 1'b1;
                    fmt_s           = IMM_I;
                end
            end
            OPC_STORE: begin
                uses_rs2_s = 1'b1;
                if (func3_s[2] || (!RV64 && (func3_s == 3'b011))) begin
                    ctrl_s.illegal = 1'b1;
                end else begin
                    ctrl_s.insttype = IT_S;
                    ctrl_s.memwrite = mem_code(func3_s);
                    ctrl_s.alusrc   = 1'b1;
                    fmt_s           = IMM_S;
                end
            end
            OPC_BRANCH: begin
                uses_rs2_s      = 1'b1;
                ctrl_s.insttype = IT_B;
                ctrl_s.aluop    = ALU_BR;
                ctrl_s.branch   = 1'b1;
                fmt_s           = IMM_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                uses_rs1_s      = 1'b0;
                ctrl_s.insttype = (opcode_s == OPC_AUIPC) ? IT_AUIPC : IT_U;
                ctrl_s.aluop    = ALU_ADD;
                ctrl_s.regwrite = 1'b1;
                ctrl_s.alusrc   = 1'b1;
                fmt_s           = IMM_U;
            end
            OPC_JAL: begin
                uses_rs1_s      = 1'b0;
                ctrl_s.insttype = IT_J;
                ctrl_s.jump     = 1'b1;
                ctrl_s.regwrite = 1'b1;
                fmt_s           = IMM_J;
            end
            OPC_JALR: begin
                ctrl_s.insttype = IT_I;
                ctrl_s.jump     = 1'b1;
                ctrl_s.regwrite = 1'b1;
                ctrl_s.alusrc   = 1'b1;
                fmt_s           = IMM_I;
            end
            default: begin
                ctrl_s.illegal = 1'b1;
            end
        endcase
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr),
        .fmt   (fmt_s),
        .imm   (imm_s)
    );

    assign hazard_s = in_valid && ex_is_load && (ex_rd != 5'd0) &&
                      ((uses_rs1_s && (rs1_s == ex_rd)) || (uses_rs2_s && (rs2_s == ex_rd)));
    assign in_ready = (!out_valid || out_ready) && !hazard_s && !flush;
    assign accept_s = in_valid && in_ready;

    // Output bundle register: flush drops, accept loads, a consumed bundle without replacement becomes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_rs1   <= 5'd0;
            out_rs2   <= 5'd0;
            out_rd    <= 5'd0;
            out_imm   <= '0;
            ctrl_r    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept_s) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            out_rs1   <= rs1_s;
            out_rs2   <= rs2_s;
            out_rd    <= in_instr[11:7];
            out_imm   <= imm_s;
            ctrl_r    <= ctrl_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of cycles spent in load-use interlock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (hazard_s && !flush && (stall_count != {STALL_CNT_W{1'b1}})) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

    assign out_aluop    = ctrl_r.aluop;
    assign out_insttype = ctrl_r.insttype;
    assign out_memread  = ctrl_r.memread;
    assign out_memwrite = ctrl_r.memwrite;
    assign out_regwrite = ctrl_r.regwrite;
    assign out_alusrc   = ctrl_r.alusrc;
    assign out_memtoreg = ctrl_r.memtoreg;
    assign out_branch   = ctrl_r.branch;
    assign out_jump     = ctrl_r.jump;
    assign out_word     = ctrl_r.word;
    assign out_illegal  = ctrl_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: an RV32 and an RV64 instance share stimulus and are checked against a behavioural model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        flush;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        out_ready;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_pc, a_out_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [2:0]  a_aluop, a_insttype, a_memread, a_memwrite;
    logic        a_regwrite, a_alusrc, a_memtoreg, a_branch, a_jump, a_word, a_illegal;
    logic [15:0] a_stall;

    logic        b_in_ready, b_out_valid;
    logic [63:0] b_out_pc, b_out_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [2:0]  b_aluop, b_insttype, b_memread, b_memwrite;
    logic        b_regwrite, b_alusrc, b_memtoreg, b_branch, b_jump, b_word, b_illegal;
    logic [1:0]  b_stall;

    logic [18:0] a_ctrl, b_ctrl;
    assign a_ctrl = {a_aluop, a_insttype, a_memread, a_memwrite, a_regwrite, a_alusrc,
                     a_memtoreg, a_branch, a_jump, a_word, a_illegal};
    assign b_ctrl = {b_aluop, b_insttype, b_memread, b_memwrite, b_regwrite, b_alusrc,
                     b_memtoreg, b_branch, b_jump, b_word, b_illegal};

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .STALL_CNT_W(16)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
        .in_pc(in_pc[31:0]), .flush(flush), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc), .out_rs1(a_rs1),
        .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_out_imm), .out_aluop(a_aluop),
        .out_insttype(a_insttype), .out_memread(a_memread), .out_memwrite(a_memwrite),
        .out_regwrite(a_regwrite), .out_alusrc(a_alusrc), .out_memtoreg(a_memtoreg),
        .out_branch(a_branch), .out_jump(a_jump), .out_word(a_word), .out_illegal(a_illegal),
        .stall_count(a_stall)
    );

    decode_stage #(.XLEN(64), .STALL_CNT_W(2)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc), .out_rs1(b_rs1),
        .out_rs2(b_rs2), .out_rd(b_rd), .out_imm(b_out_imm), .out_aluop(b_aluop),
        .out_insttype(b_insttype), .out_memread(b_memread), .out_memwrite(b_memwrite),
        .out_regwrite(b_regwrite), .out_alusrc(b_alusrc), .out_memtoreg(b_memtoreg),
        .out_branch(b_branch), .out_jump(b_jump), .out_word(b_word), .out_illegal(b_illegal),
        .stall_count(b_stall)
    );

    typedef struct packed {
        logic [18:0] ctrl;
        logic [14:0] regs;
        logic [63:0] imm;
        logic [63:0] pc;
    } bundle_t;

    int checks   = 0;
    int failures = 0;

    bundle_t m_b32, m_b64;
    bit      m_valid;
    longint  m_cnt;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [63:0] pc, input bit rv64);
        bundle_t    b;
        logic [6:0] opc;
        logic [2:0] f3, it, alu, mr, mw;
        logic       rw, as, m2r, br, jp, wd, ill;
        longint     sx, imm, i_imm, s_imm, b_imm, u_imm, j_imm;
        opc = ins[6:0];
        f3  = ins[14:12];
        sx  = longint'($signed(ins));
        i_imm = sx >>> 20;
        s_imm = ((sx >>> 25) << 5) | longint'(ins[11:7]);
        b_imm = ((sx >>> 31) << 12) | (longint'(ins[7]) << 11) | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
        u_imm = (sx >>> 12) << 12;
        j_imm = ((sx >>> 31) << 20) | (longint'(ins[19:12]) << 12) | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
        {it, alu, mr, mw, rw, as, m2r, br, jp, wd, ill} = '0;
        imm = 0;
        case (opc)
            7'h33, 7'h3b: begin ill = (opc == 7'h3b) && !rv64; alu = 3'd2; rw = 1'b1; wd = (opc == 7'h3b); end
            7'h13, 7'h1b: begin ill = (opc == 7'h1b) && !rv64; it = 3'd1; alu = 3'd3; rw = 1'b1; as = 1'b1;
                                wd = (opc == 7'h1b); imm = i_imm; end
            7'h03: begin ill = (f3 == 3'd7) || (!rv64 && (f3 == 3'd3 || f3 == 3'd6)); it = 3'd1; mr = f3 + 3'd1;
                         rw = 1'b1; as = 1'b1; m2r = 1'b1; imm = i_imm; end
            7'h23: begin ill = (f3 > 3'd3) || (!rv64 && f3 == 3'd3); it = 3'd2; mw = f3 + 3'd1; as = 1'b1; imm = s_imm; end
            7'h63: begin it = 3'd3; alu = 3'd5; br = 1'b1; imm = b_imm; end
            7'h37: begin it = 3'd4; rw = 1'b1; as = 1'b1; imm = u_imm; end
            7'h17: begin it = 3'd6; rw = 1'b1; as = 1'b1; imm = u_imm; end
            7'h6f: begin it = 3'd5; jp = 1'b1; rw = 1'b1; imm = j_imm; end
            7'h67: begin it = 3'd1; jp = 1'b1; rw = 1'b1; as = 1'b1; imm = i_imm; end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            {it, alu, mr, mw, rw, as, m2r, br, jp, wd} = '0;
            imm = 0;
        end
        b.ctrl = {alu, it, mr, mw, rw, as, m2r, br, jp, wd, ill};
        b.regs = {ins[19:15], ins[24:20], ins[11:7]};
        b.imm  = imm;
        b.pc   = pc;
        return b;
    endfunction

    function automatic bit ref_hazard(input logic [31:0] ins, input logic v, input logic ld, input logic [4:0] erd);
        bit u1, u2;
        u1 = !(ins[6:0] inside {7'h37, 7'h17, 7'h6f});
        u2 = ins[6:0] inside {7'h33, 7'h3b, 7'h23, 7'h63};
        return v && ld && (erd != 5'd0) && ((u1 && ins[19:15] == erd) || (u2 && ins[24:20] == erd));
    endfunction

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic compare_outputs();
        bit rdy;
        rdy = (!m_valid || out_ready) && !ref_hazard(in_instr, in_valid, ex_is_load, ex_rd) && !flush;
        check_value("in_ready32", 64'(a_in_ready), 64'(rdy));
        check_value("in_ready64", 64'(b_in_ready), 64'(rdy));
        check_value("valid32", 64'(a_out_valid), 64'(m_valid));
        check_value("valid64", 64'(b_out_valid), 64'(m_valid));
        check_value("stall32", 64'(a_stall), sat(m_cnt, 65535));
        check_value("stall64", 64'(b_stall), sat(m_cnt, 3));
        if (m_valid) begin
            check_value("ctrl32", 64'(a_ctrl), 64'(m_b32.ctrl));
            check_value("regs32", 64'({a_rs1, a_rs2, a_rd}), 64'(m_b32.regs));
            check_value("imm32", 64'(a_out_imm), 64'(m_b32.imm[31:0]));
            check_value("pc32", 64'(a_out_pc), 64'(m_b32.pc[31:0]));
            check_value("ctrl64", 64'(b_ctrl), 64'(m_b64.ctrl));
            check_value("regs64", 64'({b_rs1, b_rs2, b_rd}), 64'(m_b64.regs));
            check_value("imm64", b_out_imm, m_b64.imm);
            check_value("pc64", b_out_pc, m_b64.pc);
        end
    endtask

    task automatic model_update();
        bit hz, rdy;
        hz  = ref_hazard(in_instr, in_valid, ex_is_load, ex_rd);
        rdy = (!m_valid || out_ready) && !hz && !flush;
        if (flush) begin
            m_valid = 1'b0;
        end else if (in_valid && rdy) begin
            m_valid = 1'b1;
            m_b32   = ref_decode(in_instr, in_pc, 1'b0);
            m_b64   = ref_decode(in_instr, in_pc, 1'b1);
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (hz && !flush) m_cnt++;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic ld, input logic [4:0] erd,
                         input logic fl, input logic ordy);
        in_valid   = v;
        in_instr   = ins;
        in_pc      = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
        ex_is_load = ld;
        ex_rd      = erd;
        flush      = fl;
        out_ready  = ordy;
    endtask

    logic [6:0] opc_tab [12] = '{7'h03, 7'h13, 7'h17, 7'h1b, 7'h23, 7'h33,
                                 7'h37, 7'h3b, 7'h63, 7'h67, 7'h6f, 7'h0f};

    initial begin
        logic [31:0] ins;
        longint      cnt_before;
        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        m_valid = 1'b0;
        m_cnt   = 0;
        m_b32   = '0;
        m_b64   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_ctrl32", 64'({a_ctrl, a_rs1, a_rs2, a_rd}), 64'd0);
        check_value("rst_ctrl64", 64'({b_ctrl, b_rs1, b_rs2, b_rd}), 64'd0);
        check_value("rst_imm_pc", a_out_imm | a_out_pc | b_out_imm | b_out_pc, 64'd0);
        rst = 1'b0;

        // addi x1,x0,5
        drive(1'b1, 32'h00500093, 1'b0, 5'd0, 1'b0, 1'b1);
        cycle();
        check_value("addi_valid", 64'(a_out_valid), 64'd1);
        check_value("addi_fields", 64'({a_aluop, a_alusrc, a_regwrite, a_insttype, a_rd}),
                    64'({3'b011, 1'b1, 1'b1, 3'b001, 5'd1}));
        check_value("addi_imm", 64'(a_out_imm), 64'd5);

        // lw x5,8(x2) then dependent add x6,x5,x1
        drive(1'b1, 32'h00812283, 1'b0, 5'd0, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 32'h00128333, 1'b1, 5'd5, 1'b0, 1'b1);
        #1;
        check_value("lu_in_ready", 64'(a_in_ready), 64'd0);
        cycle();
        check_value("lu_bubble", 64'({a_out_valid, a_stall}), 64'({1'b0, 16'd1}));
        ex_is_load = 1'b0;
        cycle();
        check_value("add_fields", 64'({a_out_valid, a_aluop, a_rs1, a_rs2, a_rd}),
                    64'({1'b1, 3'b010, 5'd5, 5'd1, 5'd6}));

        // jal x1,8 held under backpressure
        drive(1'b1, 32'h008000EF, 1'b0, 5'd0, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 32'h00500093, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_value("jal_hold", 64'({a_out_valid, a_in_ready, a_jump, a_insttype, a_out_imm}),
                        64'({1'b1, 1'b0, 1'b1, 3'b101, 32'd8}));
        end
        out_ready = 1'b1;
        cycle();
        check_value("after_hold", 64'({a_out_valid, a_aluop}), 64'({1'b1, 3'b011}));

        // flush during an accept cycle
        drive(1'b1, 32'h00500093, 1'b0, 5'd0, 1'b1, 1'b1);
        cnt_before = m_cnt;
        #1;
        check_value("flush_in_ready", 64'(a_in_ready), 64'd0);
        cycle();
        check_value("flush_out", 64'({a_out_valid, a_stall}), 64'({1'b0, 16'(cnt_before)}));

        // ld x0,0(x1): illegal on RV32, legal on RV64
        drive(1'b1, 32'h0000B003, 1'b0, 5'd0, 1'b0, 1'b1);
        cycle();
        check_value("ld32", 64'({a_out_valid, a_illegal, a_memread, a_regwrite}), 64'({1'b1, 1'b1, 3'b000, 1'b0}));
        check_value("ld64", 64'({b_out_valid, b_illegal, b_memread, b_regwrite}), 64'({1'b1, 1'b0, 3'b100, 1'b1}));

        // sustained hazard: saturation on the narrow counter, then reset mid-stall
        drive(1'b1, 32'h00128333, 1'b1, 5'd5, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cycle();
        check_value("stall_seven", 64'(a_stall), 64'd7);
        check_value("stall_sat", 64'(b_stall), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        check_value("async_rst", 64'({a_out_valid, b_out_valid, a_stall, b_stall}), 64'd0);
        m_valid = 1'b0;
        m_cnt   = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            ins        = $urandom;
            ins[6:0]   = opc_tab[$urandom_range(0, 11)];
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            drive($urandom_range(0, 9) < 8, ins, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32/RV64 instruction decode stage that sits between the IF/ID pipeline register and the EX stage.
- Turns a fetched instruction into the team's existing control bundle (ALUOp, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, Branch, Jump, InstType) plus register indices and a sign-extended immediate.
- Adds over the old combinational control unit: valid/ready handshake, load-use interlock, flush, AUIPC, RV64 W-ops, illegal detection, saturating stall counter.

Parameters:
- XLEN, 32, datapath width (32 or 64); sets immediate width and RV64 legality.
- STALL_CNT_W, 16, width of the saturating load-use stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  IF/ID holds a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- flush  in  1  kill the held and incoming instruction (branch/jump redirect).
- ex_is_load  in  1  instruction currently in EX is a load.
- ex_rd  in  5  destination of the EX instruction.
- out_valid  out  1  decoded bundle is valid.
- out_ready  in  1  EX accepts the bundle.
- out_pc  out  XLEN  registered PC.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_imm  out  XLEN  sign-extended immediate.
- out_aluop  out  3  ALU op.
- out_insttype  out  3  instruction type.
- out_memread, out_memwrite  out  3 each  load/store size codes.
- out_regwrite, out_alusrc, out_memtoreg, out_branch, out_jump  out  1 each  control flags.
- out_word  out  1  RV64 32-bit W-op.
- out_illegal  out  1  undecodable or unsupported instruction.
- stall_count  out  STALL_CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset (async, rst=1): every out_* cleared to 0, including out_valid; stall_count=0.
- Latency: one cycle. A bundle accepted at edge N is visible on out_* after edge N.
- Handshake:
  - out_* stay stable while out_valid && !out_ready.
  - in_ready = (!out_valid || out_ready) && !hazard && !flush.
  - Accept = in_valid && in_ready; on accept all out_* load and out_valid<=1.
  - Else if out_ready, out_valid<=0 (bubble).
- Hazard:
  - Condition: in_valid && ex_is_load && ex_rd!=0 && ((uses_rs1 && rs1==ex_rd) || (uses_rs2 && rs2==ex_rd)).
  - uses_rs1 is false for LUI/AUIPC/JAL.
  - uses_rs2 is true only for R-type, OP-32, STORE and BRANCH.
  - While hazard holds, a bubble is issued and stall_count increments, saturating at all-ones.
- Flush: highest priority. out_valid<=0 next edge and the input is not accepted. Flush together with out_ready still drops the held bundle.
- Decode encodings (unchanged from the team's control unit):
  - InstType: R=000, I=001, S=010, B=011, U=100, J=101; AUIPC uses the new code 110.
  - ALUOp: R=010, OP-IMM=011, BRANCH=101, all others 000.
  - MemRead: LB..LWU = 001..111. MemWrite: SB..SD = 001..100.
  - JALR: InstType 001, Jump=1.
  - AUIPC: RegWrite=1, ALUSrc=1, ALUOp 000.
- RV64 (XLEN=64):
  - OP-IMM-32 (0011011) decodes as OP-IMM with out_word=1.
  - OP-32 (0111011) decodes as R with out_word=1.
- XLEN=32: LD, LWU, SD, OP-32 and OP-IMM-32 set out_illegal=1 with all control flags 0 (bundle still valid, so EX traps).
- Also illegal: unknown opcode, undefined load/store func3.
- Immediates:
  - I: instr[31:20]. S: {[31:25],[11:7]}. B: {[31],[7],[30:25],[11:8],0}. J: {[31],[19:12],[20],[30:21],0}. All sign-extended to XLEN.
  - U: {[31:12],12'b0} sign-extended.
  - R-type: imm=0.
- Simultaneous events: reset > flush > hazard > accept.

Decomposition:
- Shared package (rv_ctrl_pkg): opcode constants, InstType codes, ALUOp codes, MemRead/MemWrite size codes, immediate-format enum.
- One natural sub-module: imm_gen (combinational; instr plus format in, XLEN immediate out).

Test Plan:
- XLEN=32, addi x1,x0,5 (0x00500093), out_ready=1 -> next cycle out_valid=1, aluop=011, alusrc=1, regwrite=1, insttype=001, imm=5, rd=1.
- lw x5,8(x2) (0x00812283) accepted, then EX presents ex_is_load=1, ex_rd=5 with add x6,x5,x1 (0x00128333) at input -> in_ready=0 for one cycle, one bubble (out_valid=0), stall_count=1; with ex_is_load=0 the add is accepted: aluop=010, rs1=5, rs2=1, rd=6.
- Hold out_ready=0 for 3 cycles with jal x1,8 (0x008000EF) in the output register -> out_* constant, in_ready=0, jump=1, insttype=101, imm=8; release -> next instruction accepted.
- Assert flush during an accept cycle -> in_ready=0, out_valid=0 next cycle, stall_count unchanged.
- XLEN=32, ld x0,0(x1) (0x0000B003) -> out_valid=1, out_illegal=1, memread=000, regwrite=0. XLEN=64, same word -> memread=100, illegal=0.
- Assert rst mid-stall with stall_count=7 -> immediate out_valid=0, stall_count=0; stall_count saturation checked with STALL_CNT_W=2 (sticks at 3).
